// File: rtl/watch2count_seq.sv
// watch2count_seq: serial BCD time (hh:mm:ss.mmm) to binary millisecond converter.
// Captures nine BCD digits and folds them into a millisecond count with one
// mixed-radix multiply-accumulate step per clock (shift-add only, no multiplier).
// Registers update on the falling edge of NEclk; reset is asynchronous, active-low.
// Optional build macro: W2C_RANGE_CHECK_EN enables digit range checking at capture
// (any digit > 9, or tens of minutes/seconds > 5, makes the conversion end in error).
module watch2count_seq #(
   parameter int BITS = 29
) (
   input  logic            NEclk,
   input  logic            reset,
   input  logic            start,
   input  logic [3:0]      bcd_h_1,
   input  logic [3:0]      bcd_h_0,
   input  logic [3:0]      bcd_min_1,
   input  logic [3:0]      bcd_min_0,
   input  logic [3:0]      bcd_s_1,
   input  logic [3:0]      bcd_s_0,
   input  logic [3:0]      bcd_ms_2,
   input  logic [3:0]      bcd_ms_1,
   input  logic [3:0]      bcd_ms_0,
   output logic [BITS-1:0] count,
   output logic            busy,
   output logic            done,
   output logic            error
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int ACC_W = BITS + 4;

   state_t            state_q;
   logic [8:0][3:0]   dig_q;
   logic [ACC_W-1:0]  acc_q;
   logic [3:0]        step_q;
   logic              invalid_q;
   logic [BITS-1:0]   count_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;

   // Digits in processing order: index 0 is hours tens, index 8 is ms units.
   logic [8:0][3:0]   dig_in;
   logic              invalid_d;
   logic [3:0]        dig_cur;
   logic [ACC_W-1:0]  acc_x6;
   logic [ACC_W-1:0]  acc_x10;
   logic [ACC_W-1:0]  acc_scaled;
   logic [ACC_W-1:0]  acc_d;
   logic              overflow;

   assign dig_in = {bcd_ms_0, bcd_ms_1, bcd_ms_2,
                    bcd_s_0, bcd_s_1,
                    bcd_min_0, bcd_min_1,
                    bcd_h_0, bcd_h_1};

`ifdef W2C_RANGE_CHECK_EN
   logic [8:0] dig_gt9;
   for (genvar gi = 0; gi < 9; gi++) begin : g_digit_chk
      assign dig_gt9[gi] = (dig_in[gi] > 4'd9);
   end
   // Index 2 is minutes tens, index 4 is seconds tens: both must be 0..5.
   assign invalid_d = (|dig_gt9) || (dig_in[2] > 4'd5) || (dig_in[4] > 4'd5);
`else
   assign invalid_d = 1'b0;
`endif

   // Shift-add scaling of the accumulator by the radix of the current step.
   assign acc_x6  = (acc_q << 2) + (acc_q << 1);
   assign acc_x10 = (acc_q << 3) + (acc_q << 1);

   // Select the digit and radix for the current step and form the next accumulator.
   always_comb begin
      dig_cur    = 4'd0;
      acc_scaled = acc_x10;
      if (step_q < 4'd9) begin
         dig_cur = dig_q[step_q];
      end
      case (step_q)
         4'd0:       acc_scaled = acc_q;
         4'd2, 4'd4: acc_scaled = acc_x6;
         default:    acc_scaled = acc_x10;
      endcase
      acc_d = acc_scaled + {{BITS{1'b0}}, dig_cur};
   end

   // Anything above the count width means the result does not fit.
   assign overflow = |acc_q[ACC_W-1:BITS];

   // Control FSM with registered outputs; done is a single-cycle pulse.
   always_ff @(negedge NEclk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         dig_q     <= '0;
         acc_q     <= '0;
         step_q    <= 4'd0;
         invalid_q <= 1'b0;
         count_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A start coinciding with the done pulse is deliberately not taken,
               // so done can never be asserted on consecutive cycles.
               if (start && !done_q) begin
                  dig_q     <= dig_in;
                  invalid_q <= invalid_d;
                  acc_q     <= '0;
                  step_q    <= 4'd0;
                  busy_q    <= 1'b1;
                  error_q   <= 1'b0;
                  state_q   <= CALC;
               end
            end
            CALC: begin
               acc_q  <= acc_d;
               step_q <= step_q + 4'd1;
               if (step_q == 4'd8) begin
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q <= 1'b1;
               busy_q <= 1'b0;
               if (invalid_q || overflow) begin
                  error_q <= 1'b1;
               end else begin
                  count_q <= acc_q[BITS-1:0];
               end
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign count = count_q;
   assign busy  = busy_q;
   assign done  = done_q;
   assign error = error_q;

endmodule

// File: tb/tb_watch2count_seq.sv
// Bench for watch2count_seq: table of BCD times with hand-computed millisecond
// values, applied to a 29-bit and a 28-bit instance, plus sequences for
// start-while-busy, reset mid-conversion, input change after capture and
// start held high.
module tb_watch2count_seq;

   logic        NEclk = 1'b1;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [3:0]  bcd_h_1 = '0, bcd_h_0 = '0, bcd_min_1 = '0, bcd_min_0 = '0;
   logic [3:0]  bcd_s_1 = '0, bcd_s_0 = '0, bcd_ms_2 = '0, bcd_ms_1 = '0, bcd_ms_0 = '0;
   logic [28:0] count29;
   logic        busy29, done29, error29;
   logic [27:0] count28;
   logic        busy28, done28, error28;

   int n_checks = 0;
   int n_fail   = 0;

   // Expected state of each instance's count/error registers.
   longint m_cnt29 = 0;
   longint m_cnt28 = 0;
   longint m_err29 = 0;
   longint m_err28 = 0;

   typedef struct {
      logic [35:0] digits;     // BCD nibbles hh mm ss mmm, most significant first
      longint      ms;         // hand-computed millisecond value
      bit          range_bad;  // minutes/seconds tens digit out of range
   } vec_t;

   vec_t vecs[11];

   always #5 NEclk = ~NEclk;

   watch2count_seq #(.BITS(29)) dut (
      .NEclk(NEclk), .reset(reset), .start(start),
      .bcd_h_1(bcd_h_1), .bcd_h_0(bcd_h_0),
      .bcd_min_1(bcd_min_1), .bcd_min_0(bcd_min_0),
      .bcd_s_1(bcd_s_1), .bcd_s_0(bcd_s_0),
      .bcd_ms_2(bcd_ms_2), .bcd_ms_1(bcd_ms_1), .bcd_ms_0(bcd_ms_0),
      .count(count29), .busy(busy29), .done(done29), .error(error29)
   );

   watch2count_seq #(.BITS(28)) dut28 (
      .NEclk(NEclk), .reset(reset), .start(start),
      .bcd_h_1(bcd_h_1), .bcd_h_0(bcd_h_0),
      .bcd_min_1(bcd_min_1), .bcd_min_0(bcd_min_0),
      .bcd_s_1(bcd_s_1), .bcd_s_0(bcd_s_0),
      .bcd_ms_2(bcd_ms_2), .bcd_ms_1(bcd_ms_1), .bcd_ms_0(bcd_ms_0),
      .count(count28), .busy(busy28), .done(done28), .error(error28)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_digits(input logic [35:0] d);
      {bcd_h_1, bcd_h_0, bcd_min_1, bcd_min_0, bcd_s_1, bcd_s_0,
       bcd_ms_2, bcd_ms_1, bcd_ms_0} = d;
   endtask

   // Expected register contents after a completed conversion of v.
   task automatic model_update(input vec_t v);
      bit bad;
      bad = 1'b0;
`ifdef W2C_RANGE_CHECK_EN
      bad = v.range_bad;
`endif
      m_err29 = (bad || (v.ms >= (64'd1 << 29))) ? 1 : 0;
      if (m_err29 == 0) m_cnt29 = v.ms;
      m_err28 = (bad || (v.ms >= (64'd1 << 28))) ? 1 : 0;
      if (m_err28 == 0) m_cnt28 = v.ms;
   endtask

   task automatic check_results(input string tag);
      check({tag, " count29"}, longint'(count29), m_cnt29);
      check({tag, " error29"}, longint'(error29), m_err29);
      check({tag, " count28"}, longint'(count28), m_cnt28);
      check({tag, " error28"}, longint'(error28), m_err28);
   endtask

   // One conversion; poke_k re-pulses start after that cycle, chg_k alters the digits.
   task automatic run_conv(input vec_t v, input int poke_k, input int chg_k, input string tag);
      int first_done;
      int pulses;
      int busy_cyc;
      first_done = -1;
      pulses     = 0;
      busy_cyc   = 0;
      @(posedge NEclk);
      set_digits(v.digits);
      start = 1'b1;
      @(negedge NEclk);
      @(posedge NEclk);
      start = 1'b0;
      if (busy29) busy_cyc++;
      for (int k = 1; k <= 12; k++) begin
         @(negedge NEclk);
         @(posedge NEclk);
         if (done29) begin
            pulses++;
            if (first_done < 0) first_done = k;
         end
         if (busy29) busy_cyc++;
         if (poke_k > 0 && k == poke_k) start = 1'b1;
         if (poke_k > 0 && k == poke_k + 1) start = 1'b0;
         if (k == chg_k) set_digits(36'h987654321);
      end
      model_update(v);
      check({tag, " latency"}, first_done, 10);
      check({tag, " done_pulses"}, pulses, 1);
      check({tag, " busy_cycles"}, busy_cyc, 10);
      check_results(tag);
      $display("conv %s digits=%h -> count29=%0d err29=%0b count28=%0d err28=%0b",
               tag, v.digits, count29, error29, count28, error28);
   endtask

   initial begin
      int pulses;
      int d1;
      int d2;
      bit b2b;
      logic prev_done;

      vecs[0]  = '{36'h010203456, 64'd3723456,   1'b0};
      vecs[1]  = '{36'h995959999, 64'd359999999, 1'b0};
      vecs[2]  = '{36'h006000000, 64'd3600000,   1'b1};
      vecs[3]  = '{36'h000000000, 64'd0,         1'b0};
      vecs[4]  = '{36'h000000001, 64'd1,         1'b0};
      vecs[5]  = '{36'h123456789, 64'd45296789,  1'b0};
      vecs[6]  = '{36'h235959999, 64'd86399999,  1'b0};
      vecs[7]  = '{36'h800000000, 64'd288000000, 1'b0};
      vecs[8]  = '{36'h000070000, 64'd70000,     1'b1};
      vecs[9]  = '{36'h100000000, 64'd36000000,  1'b0};
      vecs[10] = '{36'h000059000, 64'd59000,     1'b0};

      // Reset state
      repeat (3) @(negedge NEclk);
      @(posedge NEclk);
      check("reset count29", longint'(count29), 0);
      check("reset busy29",  longint'(busy29),  0);
      check("reset done29",  longint'(done29),  0);
      check("reset error29", longint'(error29), 0);
      check("reset count28", longint'(count28), 0);
      check("reset busy28",  longint'(busy28),  0);
      reset = 1'b1;

      // Table of conversions
      for (int i = 0; i < 11; i++) begin
         run_conv(vecs[i], 0, 0, $sformatf("vec%0d", i));
      end

      // Start pulsed again while busy: ignored
      run_conv(vecs[0], 4, 0, "busy_start");

      // Digits change two cycles after capture: captured value wins
      run_conv(vecs[5], 0, 2, "input_change");

      // Reset during step 5: immediate abort, no done pulse
      @(posedge NEclk);
      set_digits(vecs[6].digits);
      start = 1'b1;
      @(negedge NEclk);
      @(posedge NEclk);
      start = 1'b0;
      repeat (5) begin
         @(negedge NEclk);
         @(posedge NEclk);
      end
      reset = 1'b0;
      #1;
      check("midreset count29", longint'(count29), 0);
      check("midreset busy29",  longint'(busy29),  0);
      check("midreset error29", longint'(error29), 0);
      check("midreset count28", longint'(count28), 0);
      @(negedge NEclk);
      @(posedge NEclk);
      reset = 1'b1;
      m_cnt29 = 0;
      m_cnt28 = 0;
      m_err29 = 0;
      m_err28 = 0;
      pulses = 0;
      for (int k = 0; k < 15; k++) begin
         @(negedge NEclk);
         @(posedge NEclk);
         if (done29 || done28) pulses++;
      end
      check("midreset no_done", pulses, 0);
      $display("conv midreset aborted -> count29=%0d busy29=%0b", count29, busy29);
      run_conv(vecs[0], 0, 0, "after_reset");

      // Start held high: back-to-back conversions with a gap between done pulses
      pulses    = 0;
      d1        = -1;
      d2        = -1;
      b2b       = 1'b0;
      prev_done = 1'b0;
      @(posedge NEclk);
      set_digits(vecs[9].digits);
      start = 1'b1;
      @(negedge NEclk);
      @(posedge NEclk);
      for (int k = 1; k <= 26; k++) begin
         @(negedge NEclk);
         @(posedge NEclk);
         if (done29) begin
            pulses++;
            if (prev_done) b2b = 1'b1;
            if (d1 < 0) d1 = k;
            else if (d2 < 0) d2 = k;
         end
         prev_done = done29;
         if (k == 22) start = 1'b0;
      end
      model_update(vecs[9]);
      check("held_start pulses", pulses, 2);
      check("held_start first_done", d1, 10);
      check("held_start second_done", d2, 22);
      check("held_start back_to_back", longint'(b2b), 0);
      check_results("held_start");
      $display("conv held_start digits=%h -> count29=%0d dones=%0d", vecs[9].digits, count29, pulses);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
